uart_rx_os: RTL and testbench

- Oversampling UART receiver. It is the far-end listener for the existing serial transmitter: it accepts 8N1 frames on a single-wire line and hands decoded bytes to a consumer through a valid/ready holding register.
- It is more robust than the baud-clock receiver inside uart_top. It uses a 2-flop synchronizer, oversampled majority voting, false-start rejection, framing-error and overrun flags, and line-idle recovery.
- It is used as a standalone checker/receiver on the tx line in system benches, and as a drop-in RX for the top level.

---
 rtl/uart_rx_os.sv | 183 ++++++++++++++++++
 tb/tb_uart_rx_os.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_os.sv
// Oversampling 8N1 UART receiver: 2-flop synchronizer, 2-of-3 mid-bit voting,
// false-start rejection, framing/overrun flags and a valid/ready holding register.
module uart_rx_os #(
    parameter int unsigned CLK_FREQ   = 1000000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned OVERSAMPLE = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] dout,
    output logic       dout_valid,
    input  logic       dout_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int unsigned DIV  = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int unsigned MID  = OVERSAMPLE / 2;
    localparam int unsigned DivW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned OsW  = $clog2(OVERSAMPLE);

    localparam logic [DivW-1:0] DivLast = DivW'(DIV - 1);
    localparam logic [OsW-1:0]  OsLast  = OsW'(OVERSAMPLE - 1);
    localparam logic [OsW-1:0]  OsLo    = OsW'(MID - 1);
    localparam logic [OsW-1:0]  OsMid   = OsW'(MID);
    localparam logic [OsW-1:0]  OsHi    = OsW'(MID + 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StWaitIdle
    } state_e;

    state_e          state_q, state_d;
    logic            rx_meta_q, rx_s_q;
    logic [DivW-1:0] div_cnt_q, div_cnt_d;
    logic [OsW-1:0]  os_cnt_q, os_cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [2:0]      smp_q, smp_d;
    logic [7:0]      shreg_q, shreg_d;
    logic [7:0]      dout_q, dout_d;
    logic            dout_valid_q, dout_valid_d;
    logic            frame_err_q, frame_err_d;
    logic            overrun_q, overrun_d;

    logic tick;
    logic vote_full;
    logic vote_stop;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    assign tick      = (div_cnt_q == DivLast);
    assign vote_full = maj3(smp_q[0], smp_q[1], smp_q[2]);
    // The stop decision lands on the third sample tick, so use the live sample.
    assign vote_stop = maj3(smp_q[0], smp_q[1], rx_s_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_comb begin
        state_d      = state_q;
        div_cnt_d    = div_cnt_q;
        os_cnt_d     = os_cnt_q;
        bit_idx_d    = bit_idx_q;
        smp_d        = smp_q;
        shreg_d      = shreg_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        frame_err_d  = frame_err_q;
        overrun_d    = 1'b0;

        if (state_q == StIdle) begin
            div_cnt_d = '0;
            os_cnt_d  = '0;
        end else begin
            div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
            if (tick) begin
                os_cnt_d = (os_cnt_q == OsLast) ? '0 : os_cnt_q + 1'b1;
                if (os_cnt_q == OsLo)  smp_d[0] = rx_s_q;
                if (os_cnt_q == OsMid) smp_d[1] = rx_s_q;
                if (os_cnt_q == OsHi)  smp_d[2] = rx_s_q;
            end
        end

        if (dout_valid_q && dout_ready) begin
            dout_valid_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (!rx_s_q) begin
                    state_d   = StStart;
                    bit_idx_d = '0;
                end
            end
            StStart: begin
                if (tick && os_cnt_q == OsLast) begin
                    if (vote_full) begin
                        state_d = StIdle;
                    end else begin
                        state_d   = StData;
                        bit_idx_d = '0;
                    end
                end
            end
            StData: begin
                if (tick && os_cnt_q == OsLast) begin
                    shreg_d[bit_idx_q] = vote_full;
                    if (bit_idx_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            StStop: begin
                if (tick && os_cnt_q == OsHi) begin
                    if (!dout_valid_q || dout_ready) begin
                        dout_d       = shreg_q;
                        frame_err_d  = ~vote_stop;
                        dout_valid_d = 1'b1;
                    end else begin
                        overrun_d = 1'b1;
                    end
                    // A low stop bit waits for the line to recover so a break yields one byte.
                    state_d = vote_stop ? StIdle : StWaitIdle;
                end
            end
            StWaitIdle: begin
                if (rx_s_q) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            div_cnt_q    <= '0;
            os_cnt_q     <= '0;
            bit_idx_q    <= '0;
            smp_q        <= '0;
            shreg_q      <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_cnt_q    <= div_cnt_d;
            os_cnt_q     <= os_cnt_d;
            bit_idx_q    <= bit_idx_d;
            smp_q        <= smp_d;
            shreg_q      <= shreg_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
    assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: 104 clk/bit frames, accepted bytes collected
// by a monitor and compared against hand-computed values.
module tb_uart_rx_os;

    localparam int BitClk   = 104;
    localparam int FrameClk = 10 * BitClk;

    logic       clk;
    logic       rst;
    logic       rx;
    logic [7:0] dout;
    logic       dout_valid;
    logic       dout_ready;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int n_checks;
    int n_errors;
    int n_ovr;
    logic [8:0] rxq[$];

    uart_rx_os #(
        .CLK_FREQ  (1000000),
        .BAUD      (9600),
        .OVERSAMPLE(8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .dout      (dout),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Collect accepted {frame_err, dout} and overrun pulses just after each falling edge.
    always begin
        @(negedge clk);
        #1;
        if (!rst) begin
            if (dout_valid && dout_ready) rxq.push_back({frame_err, dout});
            if (overrun) n_ovr++;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input logic v, input int n);
        rx = v;
        idle(n);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input int glitch_bit);
        drive(1'b0, BitClk);
        for (int i = 0; i < 8; i++) begin
            if (i == glitch_bit) begin
                drive(b[i], 52);
                drive(~b[i], 1);
                drive(b[i], BitClk - 53);
            end else begin
                drive(b[i], BitClk);
            end
        end
        drive(stop, BitClk);
        rx = 1'b1;
    endtask

    task automatic expect_byte(input string tag, input logic [8:0] exp);
        logic [8:0] got;
        got = 9'h1ff;
        if (rxq.size() > 0) got = rxq.pop_front();
        check_eq(tag, {23'd0, got}, {23'd0, exp});
    endtask

    initial begin
        int ovr_base;
        n_checks   = 0;
        n_errors   = 0;
        n_ovr      = 0;
        rst        = 1'b1;
        rx         = 1'b1;
        dout_ready = 1'b1;
        idle(3);
        check_eq("reset dout", {24'd0, dout}, 32'h0);
        check_eq("reset valid", {31'd0, dout_valid}, 32'h0);
        check_eq("reset frame_err", {31'd0, frame_err}, 32'h0);
        check_eq("reset overrun", {31'd0, overrun}, 32'h0);
        check_eq("reset busy", {31'd0, busy}, 32'h0);
        rst = 1'b0;
        idle(20);

        // Normal byte
        send_frame(8'hA5, 1'b1, -1);
        idle(100);
        check_eq("a5 count", rxq.size(), 1);
        expect_byte("a5 byte", {1'b0, 8'hA5});
        check_eq("a5 overrun", n_ovr, 0);
        check_eq("a5 busy", {31'd0, busy}, 32'h0);
        check_eq("a5 valid cleared", {31'd0, dout_valid}, 32'h0);

        // Back-to-back frames with no idle gap
        send_frame(8'h00, 1'b1, -1);
        send_frame(8'hFF, 1'b1, -1);
        send_frame(8'h3C, 1'b1, -1);
        idle(100);
        check_eq("b2b count", rxq.size(), 3);
        expect_byte("b2b 00", {1'b0, 8'h00});
        expect_byte("b2b ff", {1'b0, 8'hFF});
        expect_byte("b2b 3c", {1'b0, 8'h3C});
        check_eq("b2b overrun", n_ovr, 0);

        // False start
        drive(1'b0, 20);
        rx = 1'b1;
        idle(150);
        check_eq("false start busy", {31'd0, busy}, 32'h0);
        check_eq("false start valid", {31'd0, dout_valid}, 32'h0);
        check_eq("false start count", rxq.size(), 0);
        send_frame(8'h5A, 1'b1, -1);
        idle(100);
        expect_byte("after false start 5a", {1'b0, 8'h5A});

        // Framing error followed by a break
        send_frame(8'h81, 1'b0, -1);
        rx = 1'b0;
        idle(FrameClk);
        check_eq("break busy", {31'd0, busy}, 32'h1);
        idle(2 * FrameClk);
        check_eq("break count", rxq.size(), 1);
        expect_byte("break 81 ferr", {1'b1, 8'h81});
        rx = 1'b1;
        idle(200);
        check_eq("break released busy", {31'd0, busy}, 32'h0);
        check_eq("break released count", rxq.size(), 0);
        send_frame(8'h42, 1'b1, -1);
        idle(100);
        expect_byte("after break 42", {1'b0, 8'h42});

        // Overrun under backpressure
        dout_ready = 1'b0;
        ovr_base   = n_ovr;
        send_frame(8'h11, 1'b1, -1);
        send_frame(8'h22, 1'b1, -1);
        idle(100);
        check_eq("ovr valid", {31'd0, dout_valid}, 32'h1);
        check_eq("ovr dout held", {24'd0, dout}, 32'h11);
        check_eq("ovr frame_err", {31'd0, frame_err}, 32'h0);
        check_eq("ovr pulses", n_ovr - ovr_base, 1);
        dout_ready = 1'b1;
        idle(1);
        check_eq("ovr valid after accept", {31'd0, dout_valid}, 32'h0);
        check_eq("ovr dout after accept", {24'd0, dout}, 32'h11);
        idle(2);
        expect_byte("ovr accepted 11", {1'b0, 8'h11});
        check_eq("ovr queue empty", rxq.size(), 0);

        // Reset mid-frame while a byte is held
        dout_ready = 1'b0;
        send_frame(8'h3C, 1'b1, -1);
        idle(50);
        check_eq("pre-reset held", {24'd0, dout}, 32'h3C);
        drive(1'b0, BitClk);
        for (int i = 0; i < 5; i++) drive(1'b1, BitClk);
        idle(50);
        check_eq("pre-reset busy", {31'd0, busy}, 32'h1);
        rst = 1'b1;
        idle(5);
        check_eq("mid reset dout", {24'd0, dout}, 32'h0);
        check_eq("mid reset valid", {31'd0, dout_valid}, 32'h0);
        check_eq("mid reset frame_err", {31'd0, frame_err}, 32'h0);
        check_eq("mid reset overrun", {31'd0, overrun}, 32'h0);
        check_eq("mid reset busy", {31'd0, busy}, 32'h0);
        rst        = 1'b0;
        dout_ready = 1'b1;
        idle(FrameClk + 200);
        check_eq("post reset valid", {31'd0, dout_valid}, 32'h0);
        check_eq("post reset count", rxq.size(), 0);

        // Glitch in the centre of data bit 3
        send_frame(8'h00, 1'b1, 3);
        idle(100);
        check_eq("glitch count", rxq.size(), 1);
        expect_byte("glitch 00", {1'b0, 8'h00});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
